ahb_lite_led_slave: RTL and testbench

//  AHB-Lite slave that terminates the PS M_AHB_0 master port in the PL. It replaces
//   the switch-driven hready/hresp ties with a real handshake.

---
 rtl/ahb_pkg.sv | 43 ++++
 rtl/sync_2ff.sv | 27 ++
 rtl/ahb_lite_led_slave.sv | 203 ++++++++++++++++++++
 tb/tb_ahb_lite_led_slave.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite codes, register offsets and FSM encoding
// for the LED slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [7:0] OFF_LED_CTRL = 8'h00;
    localparam logic [7:0] OFF_SW_STAT  = 8'h04;
    localparam logic [7:0] OFF_SCRATCH  = 8'h08;
    localparam logic [7:0] OFF_WR_CNT   = 8'h0C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Little-endian byte-lane enables for an aligned access.
    function automatic logic [3:0] byte_lanes(
        input logic [2:0] size,
        input logic [1:0] lo
    );
        logic [3:0] lanes;
        case (size)
            HSIZE_BYTE: lanes = 4'b0001 << lo;
            HSIZE_HALF: lanes = lo[1] ? 4'b1100 : 4'b0011;
            default:    lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Each bit is synchronised independently.
module sync_2ff #(
    parameter int WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ahb_lite_led_slave.sv
// AHB-Lite slave with LED, switch, scratch and write-counter registers,
// configurable wait states and a two-cycle ERROR response.
module ahb_lite_led_slave
    import ahb_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 12
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic        hmastlock,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic        hready_out,
    output logic        hresp,
    output logic [31:0] hrdata,
    input  logic [1:0]  sw,
    output logic [3:0]  led
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t      r_state;
    state_t      w_state_nx;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nx;
    logic        r_dp_valid;
    logic        w_dp_nx;

    logic        r_write;
    logic [2:0]  r_size;
    logic [1:0]  r_lo;
    // one-hot: [0] LED_CTRL, [1] SW_STAT, [2] SCRATCH, [3] WR_CNT
    logic [3:0]  r_hit;

    logic [3:0]  r_led;
    logic [31:0] r_scratch;
    logic [31:0] r_wr_cnt;
    logic [1:0]  w_sw;

    logic              w_hready;
    logic              w_hresp;
    logic [31:0]       w_rdata;
    logic              w_active;
    logic              w_accept;
    logic              w_final;
    logic              w_commit;
    logic [3:0]        w_lanes;
    logic [ADDR_W-1:0] w_off;
    logic [3:0]        w_hit;
    logic              w_mapped;
    logic              w_ro;
    logic              w_misalign;
    logic              w_badsize;
    logic              w_err;
    logic              w_unused;

    assign w_unused = ^{hburst, hprot, hmastlock, haddr[31:ADDR_W]};

    sync_2ff #(
        .WIDTH(2)
    ) u_sw_sync (
        .i_clk(hclk),
        .i_rst(hreset),
        .i_d  (sw),
        .o_q  (w_sw)
    );

    assign w_off = {haddr[ADDR_W-1:2], 2'b00};
    assign w_hit = {
        w_off == ADDR_W'(OFF_WR_CNT),
        w_off == ADDR_W'(OFF_SCRATCH),
        w_off == ADDR_W'(OFF_SW_STAT),
        w_off == ADDR_W'(OFF_LED_CTRL)
    };

    assign w_mapped   = |w_hit;
    assign w_ro       = w_hit[1] | w_hit[3];
    assign w_badsize  = hsize > HSIZE_WORD;
    assign w_misalign = ((hsize == HSIZE_HALF) & haddr[0])
                      | ((hsize == HSIZE_WORD) & (|haddr[1:0]));
    assign w_err      = ~w_mapped | (hwrite & w_ro) | w_badsize | w_misalign;

    assign w_active = (htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ);
    assign w_accept = hsel & hready_in & w_active & w_hready;
    assign w_final  = r_dp_valid & w_hready;
    assign w_commit = w_final & r_write;
    assign w_lanes  = byte_lanes(r_size, r_lo);

    always_comb begin
        w_hready = 1'b1;
        w_hresp  = HRESP_OKAY;
        unique case (r_state)
            ST_IDLE: ;
            ST_WAIT: w_hready = (r_cnt == 4'd0);
            ST_ERR1: begin
                w_hready = 1'b0;
                w_hresp  = HRESP_ERROR;
            end
            ST_ERR2: w_hresp = HRESP_ERROR;
        endcase
    end

    // Any state with hready high is a point where a new
    // address phase may start, including ERR2.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_dp_nx    = r_dp_valid;
        if (r_state == ST_ERR1) begin
            w_state_nx = ST_ERR2;
        end else if (!w_hready) begin
            w_cnt_nx = r_cnt - 4'd1;
        end else if (w_accept) begin
            if (w_err) begin
                w_state_nx = ST_ERR1;
                w_dp_nx    = 1'b0;
            end else if (WAIT_STATES > 0) begin
                w_state_nx = ST_WAIT;
                w_cnt_nx   = WS;
                w_dp_nx    = 1'b1;
            end else begin
                w_state_nx = ST_IDLE;
                w_dp_nx    = 1'b1;
            end
        end else begin
            w_state_nx = ST_IDLE;
            w_dp_nx    = 1'b0;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_dp_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_dp_valid <= w_dp_nx;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_write <= 1'b0;
            r_size  <= 3'd0;
            r_lo    <= 2'd0;
            r_hit   <= 4'd0;
        end else if (w_accept) begin
            r_write <= hwrite;
            r_size  <= hsize;
            r_lo    <= haddr[1:0];
            r_hit   <= w_hit;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_led     <= 4'd0;
            r_scratch <= 32'd0;
            r_wr_cnt  <= 32'd0;
        end else if (w_commit) begin
            r_wr_cnt <= r_wr_cnt + 32'd1;
            if (r_hit[0] && w_lanes[0]) begin
                r_led <= hwdata[3:0];
            end
            if (r_hit[2]) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_lanes[i]) begin
                        r_scratch[8*i +: 8] <= hwdata[8*i +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_final && !r_write) begin
            unique case (1'b1)
                r_hit[0]: w_rdata = {28'd0, r_led};
                r_hit[1]: w_rdata = {30'd0, w_sw};
                r_hit[2]: w_rdata = r_scratch;
                r_hit[3]: w_rdata = r_wr_cnt;
                default:  w_rdata = 32'd0;
            endcase
        end
    end

    assign hready_out = w_hready;
    assign hresp      = w_hresp;
    assign hrdata     = w_rdata;
    assign led        = r_led;

endmodule

// File: tb/tb_ahb_lite_led_slave.sv
// Scoreboard bench for ahb_lite_led_slave: one instance with no wait
// states and one with three, sharing a single pipelined bus master.
`timescale 1ns/1ps
module tb_ahb_lite_led_slave;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [1:0]  trans;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic        resp;
        logic        rd;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel = 1'b1;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [2:0]  hburst = '0;
    logic [3:0]  hprot = '0;
    logic        hmastlock = 1'b0;
    logic [31:0] hwdata = '0;
    logic [1:0]  sw = '0;
    logic        which = 1'b0;

    logic        sel0, sel3;
    logic        hready0, hresp0, hready3, hresp3;
    logic [31:0] hrdata0, hrdata3;
    logic [3:0]  led0, led3;

    assign sel0 = hsel & ~which;
    assign sel3 = hsel & which;

    ahb_lite_led_slave #(.WAIT_STATES(0), .ADDR_W(12)) u_dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(sel0), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
        .hready_in(hready0), .hready_out(hready0), .hresp(hresp0),
        .hrdata(hrdata0), .sw(sw), .led(led0)
    );

    ahb_lite_led_slave #(.WAIT_STATES(3), .ADDR_W(12)) u_dut3 (
        .hclk(hclk), .hreset(hreset), .hsel(sel3), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
        .hready_in(hready3), .hready_out(hready3), .hresp(hresp3),
        .hrdata(hrdata3), .sw(sw), .led(led3)
    );

    always #5 hclk = ~hclk;

    int tests = 0;
    int fails = 0;

    logic [3:0]  m_led [2];
    logic [31:0] m_scr [2];
    logic [31:0] m_cnt [2];
    logic [1:0]  m_sw;

    req_t q_req [$];
    exp_t q_exp [$];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_led[d] = '0;
            m_scr[d] = '0;
            m_cnt[d] = '0;
        end
    endtask

    function automatic bit exp_err(logic [31:0] a, logic w, logic [2:0] s);
        bit e = 0;
        if (s > 3'd2) e = 1;
        if (s == 3'd1 && a[0]) e = 1;
        if (s == 3'd2 && a[1:0] != 2'd0) e = 1;
        case (a[11:2])
            10'd0, 10'd2: ;
            10'd1, 10'd3: if (w) e = 1;
            default: e = 1;
        endcase
        return e;
    endfunction

    task automatic model_accept(input req_t r, output exp_t e);
        int d;
        int lo;
        int n;
        d = which ? 1 : 0;
        e.addr  = r.addr;
        e.rd    = !r.wr;
        e.rdata = '0;
        if (exp_err(r.addr, r.wr, r.size)) begin
            e.resp  = 1'b1;
            e.waits = 1;
        end else begin
            e.resp  = 1'b0;
            e.waits = which ? 3 : 0;
            if (r.wr) begin
                n  = 1 << r.size;
                lo = int'(r.addr[1:0]);
                for (int i = 0; i < 4; i++) begin
                    if (i >= lo && i < lo + n) begin
                        if (r.addr[11:2] == 10'd0 && i == 0) m_led[d] = r.wdata[3:0];
                        if (r.addr[11:2] == 10'd2) m_scr[d][8*i +: 8] = r.wdata[8*i +: 8];
                    end
                end
                m_cnt[d] = m_cnt[d] + 32'd1;
            end else begin
                case (r.addr[11:2])
                    10'd0: e.rdata = {28'd0, m_led[d]};
                    10'd1: e.rdata = {30'd0, m_sw};
                    10'd2: e.rdata = m_scr[d];
                    default: e.rdata = m_cnt[d];
                endcase
            end
        end
    endtask

    task automatic add(input logic [31:0] a, input logic w, input logic [2:0] s,
                       input logic [31:0] wd, input logic [1:0] t);
        req_t r;
        r.addr = a; r.wr = w; r.size = s; r.wdata = wd; r.trans = t;
        q_req.push_back(r);
    endtask

    // Pipelined master; called at posedge+1, returns at posedge+1.
    task automatic run_bus(output int cycles);
        exp_t        e;
        exp_t        cur;
        req_t        r;
        bit          act;
        int          low;
        logic [31:0] dwd;
        logic        rdy, rsp;
        logic [31:0] rd;
        act = 0; low = 0; dwd = '0; cycles = 0;
        while ((q_req.size() > 0 || act) && cycles < 400) begin
            hwdata = dwd;
            if (q_req.size() > 0) begin
                haddr  = q_req[0].addr;
                hwrite = q_req[0].wr;
                hsize  = q_req[0].size;
                htrans = q_req[0].trans;
            end else begin
                htrans = 2'd0;
            end
            @(negedge hclk);
            cycles++;
            rdy = which ? hready3 : hready0;
            rsp = which ? hresp3 : hresp0;
            rd  = which ? hrdata3 : hrdata0;
            if (act) begin
                tests++;
                if (rsp !== q_exp[0].resp) begin
                    fails++;
                    $display("FAIL hresp addr=%h: got %b want %b", q_exp[0].addr, rsp, q_exp[0].resp);
                end
                if (!rdy) low++;
                else begin
                    cur = q_exp.pop_front();
                    tests++;
                    if (low != cur.waits) begin
                        fails++;
                        $display("FAIL waits addr=%h: got %0d want %0d", cur.addr, low, cur.waits);
                    end
                    if (cur.rd) begin
                        tests++;
                        if (rd !== cur.rdata) begin
                            fails++;
                            $display("FAIL hrdata addr=%h: got %h want %h", cur.addr, rd, cur.rdata);
                        end
                    end
                    act = 0;
                end
            end
            if (rdy && q_req.size() > 0) begin
                r = q_req.pop_front();
                model_accept(r, e);
                q_exp.push_back(e);
                dwd = r.wdata;
                act = 1;
                low = 0;
            end
            @(posedge hclk);
            #1;
        end
        htrans = 2'd0;
        if (act || q_req.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d cycles want completion", cycles);
            q_req.delete();
            q_exp.delete();
        end
    endtask

    task automatic test_reset();
        model_reset();
        m_sw = 2'b00;
        #2;
        tests++;
        if ({hready0, hresp0, hrdata0, led0} !== {1'b1, 1'b0, 32'h0, 4'h0}) begin
            fails++;
            $display("FAIL reset0: got %b %b %h %h want 1 0 0 0", hready0, hresp0, hrdata0, led0);
        end
        tests++;
        if ({hready3, hresp3, hrdata3, led3} !== {1'b1, 1'b0, 32'h0, 4'h0}) begin
            fails++;
            $display("FAIL reset3: got %b %b %h %h want 1 0 0 0", hready3, hresp3, hrdata3, led3);
        end
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(posedge hclk); #1;
    endtask

    task automatic test_led_rw();
        int c;
        which = 1'b0;
        add(32'h0, 1, 3'd2, 32'h0000_000A, 2'd2);
        add(32'h0, 0, 3'd2, 32'h0, 2'd2);
        run_bus(c);
        tests++;
        if (led0 !== m_led[0]) begin
            fails++;
            $display("FAIL led0: got %h want %h", led0, m_led[0]);
        end
    endtask

    task automatic test_wait_states();
        int c;
        which = 1'b1;
        add(32'h8, 1, 3'd2, 32'hDEAD_BEEF, 2'd2);
        add(32'h8, 0, 3'd2, 32'h0, 2'd2);
        add(32'hC, 0, 3'd2, 32'h0, 2'd2);
        run_bus(c);
    endtask

    task automatic test_errors();
        int c;
        which = 1'b1;
        add(32'hC, 1, 3'd2, 32'h5, 2'd2);
        add(32'h10, 0, 3'd2, 32'h0, 2'd2);
        add(32'hC, 0, 3'd2, 32'h0, 2'd2);
        add(32'h0, 0, 3'd3, 32'h0, 2'd2);
        add(32'h2, 0, 3'd2, 32'h0, 2'd2);
        add(32'hFFFF_F008, 0, 3'd2, 32'h0, 2'd2);
        run_bus(c);
    endtask

    task automatic test_byte_lanes();
        int c;
        which = 1'b0;
        add(32'h8, 1, 3'd2, 32'h0, 2'd2);
        add(32'h9, 1, 3'd0, 32'h0000_5500, 2'd2);
        add(32'h8, 0, 3'd2, 32'h0, 2'd2);
        add(32'h9, 1, 3'd1, 32'h1234_5678, 2'd2);
        add(32'hA, 1, 3'd1, 32'hBEEF_0000, 2'd2);
        add(32'h8, 0, 3'd2, 32'h0, 2'd2);
        add(32'h1, 1, 3'd0, 32'h0000_0F00, 2'd2);
        add(32'h0, 0, 3'd2, 32'h0, 2'd2);
        run_bus(c);
        tests++;
        if (led0 !== m_led[0]) begin
            fails++;
            $display("FAIL led0_lane: got %h want %h", led0, m_led[0]);
        end
    endtask

    task automatic test_sw();
        int c;
        sw = 2'b10;
        m_sw = 2'b10;
        repeat (3) @(posedge hclk);
        #1;
        which = 1'b0;
        add(32'h4, 0, 3'd2, 32'h0, 2'd2);
        add(32'h4, 1, 3'd2, 32'h3, 2'd2);
        run_bus(c);
    endtask

    task automatic test_back_to_back();
        int c;
        which = 1'b0;
        add(32'h08, 1, 3'd2, 32'h1111_1111, 2'd2);
        add(32'h0C, 1, 3'd2, 32'h2222_2222, 2'd3);
        add(32'h10, 1, 3'd2, 32'h3333_3333, 2'd3);
        add(32'h14, 1, 3'd2, 32'h4444_4444, 2'd3);
        add(32'h0C, 0, 3'd2, 32'h0, 2'd2);
        run_bus(c);
        add(32'h08, 1, 3'd2, 32'h0BAD_F00D, 2'd2);
        add(32'h00, 1, 3'd2, 32'h0000_0003, 2'd3);
        add(32'h08, 0, 3'd2, 32'h0, 2'd3);
        add(32'h00, 0, 3'd2, 32'h0, 2'd3);
        run_bus(c);
        tests++;
        if (c != 5) begin
            fails++;
            $display("FAIL throughput: got %0d cycles want 5", c);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        which = 1'b1;
        add(32'h0, 1, 3'd2, 32'h7, 2'd2);
        run_bus(c);
        tests++;
        if (led3 !== m_led[1]) begin
            fails++;
            $display("FAIL led3: got %h want %h", led3, m_led[1]);
        end
        haddr = 32'h8; hwrite = 1'b1; hsize = 3'd2; htrans = 2'd2;
        @(negedge hclk);
        @(posedge hclk); #1;
        htrans = 2'd0;
        hwdata = 32'hCAFE_F00D;
        @(negedge hclk);
        tests++;
        if (hready3 !== 1'b0) begin
            fails++;
            $display("FAIL wait_low: got %b want 0", hready3);
        end
        #2;
        hreset = 1'b1;
        model_reset();
        #1;
        tests++;
        if ({hready3, hresp3, led3} !== {1'b1, 1'b0, 4'h0}) begin
            fails++;
            $display("FAIL async_reset: got %b %b %h want 1 0 0", hready3, hresp3, led3);
        end
        #3;
        hreset = 1'b0;
        @(posedge hclk); #1;
        add(32'hC, 0, 3'd2, 32'h0, 2'd2);
        add(32'h8, 0, 3'd2, 32'h0, 2'd2);
        add(32'h0, 0, 3'd2, 32'h0, 2'd2);
        run_bus(c);
    endtask

    initial begin
        test_reset();
        test_led_rw();
        test_wait_states();
        test_errors();
        test_byte_lanes();
        test_sw();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
